// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: A (ALU writeback) and B (load writeback). Each requester has a
// one-entry holding buffer behind a valid/ready handshake. A round-robin
// arbiter drains the buffers into a registered write stage that drives the
// register file. The block also reports pending-write hazards to decode.
//
// Handshake (both requesters): a transfer happens on a rising edge of Clk
// when X_Valid && X_Ready. X_Ready depends only on internal state (never on
// X_Valid): it is high when buffer X is empty, or when buffer X is being
// drained by the arbiter this cycle (same-cycle refill). X_Valid may be
// dropped at any time; nothing is transferred unless X_Ready was high.
//
// Ports
//   Clk, Rst_n                    clock (rising edge), async active-low reset
//   A_Valid/A_Ready/A_Reg/A_Data  requester A handshake and payload
//   B_Valid/B_Ready/B_Reg/B_Data  requester B handshake and payload
//   RegWrite/WriteRegister/WriteData  registered register-file write port
//   QueryReg1/QueryReg2           decode source registers
//   Hazard1/Hazard2               query register has an uncommitted write
//   WriteCount                    RegWrite pulses issued since reset (wraps)

module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              A_Valid,
  output logic              A_Ready,
  input  logic [ADDR_W-1:0] A_Reg,
  input  logic [DATA_W-1:0] A_Data,
  input  logic              B_Valid,
  output logic              B_Ready,
  input  logic [ADDR_W-1:0] B_Reg,
  input  logic [DATA_W-1:0] B_Data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] QueryReg1,
  input  logic [ADDR_W-1:0] QueryReg2,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic [CNT_W-1:0]  WriteCount
);

  // Holding buffers
  logic              r_a_full;
  logic [ADDR_W-1:0] r_a_reg;
  logic [DATA_W-1:0] r_a_data;
  logic              r_b_full;
  logic [ADDR_W-1:0] r_b_reg;
  logic [DATA_W-1:0] r_b_data;

  // Arbiter history: 1 when B received the most recent grant
  logic              r_last_b;

  // Write stage
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [CNT_W-1:0]  r_write_count;

  logic w_same_reg;
  logic w_grant_a;
  logic w_grant_b;
  logic w_grant;
  logic w_a_take;
  logic w_b_take;

  assign w_same_reg = (r_a_reg == r_b_reg);

  // A wins when it is alone, when B had the previous grant, or when both
  // target the same register (A holds the older instruction, so B's value
  // must land last).
  assign w_grant_a = r_a_full && (!r_b_full || w_same_reg || r_last_b);
  assign w_grant_b = r_b_full && !w_grant_a;
  assign w_grant   = w_grant_a || w_grant_b;

  assign A_Ready = !r_a_full || w_grant_a;
  assign B_Ready = !r_b_full || w_grant_b;

  // Writes to register 0 complete the handshake but are never buffered.
  assign w_a_take = A_Valid && A_Ready && (A_Reg != '0);
  assign w_b_take = B_Valid && B_Ready && (B_Reg != '0);

  assign Hazard1 = (QueryReg1 != '0) &&
                   ((r_a_full && (r_a_reg == QueryReg1)) ||
                    (r_b_full && (r_b_reg == QueryReg1)) ||
                    (r_reg_write && (r_write_reg == QueryReg1)));

  assign Hazard2 = (QueryReg2 != '0) &&
                   ((r_a_full && (r_a_reg == QueryReg2)) ||
                    (r_b_full && (r_b_reg == QueryReg2)) ||
                    (r_reg_write && (r_write_reg == QueryReg2)));

  assign RegWrite      = r_reg_write;
  assign WriteRegister = r_write_reg;
  assign WriteData     = r_write_data;
  assign WriteCount    = r_write_count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_a_full      <= 1'b0;
      r_a_reg       <= '0;
      r_a_data      <= '0;
      r_b_full      <= 1'b0;
      r_b_reg       <= '0;
      r_b_data      <= '0;
      r_last_b      <= 1'b1;
      r_reg_write   <= 1'b0;
      r_write_reg   <= '0;
      r_write_data  <= '0;
      r_write_count <= '0;
    end else begin
      // A refill takes priority over the drain of the same buffer.
      if (w_a_take) begin
        r_a_full <= 1'b1;
        r_a_reg  <= A_Reg;
        r_a_data <= A_Data;
      end else if (w_grant_a) begin
        r_a_full <= 1'b0;
      end

      if (w_b_take) begin
        r_b_full <= 1'b1;
        r_b_reg  <= B_Reg;
        r_b_data <= B_Data;
      end else if (w_grant_b) begin
        r_b_full <= 1'b0;
      end

      if (w_grant) begin
        r_reg_write   <= 1'b1;
        r_write_reg   <= w_grant_a ? r_a_reg  : r_b_reg;
        r_write_data  <= w_grant_a ? r_a_data : r_b_data;
        r_write_count <= r_write_count + CNT_W'(1);
        r_last_b      <= w_grant_b;
      end else begin
        // Index and data hold their last values while idle.
        r_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed vector table, hand-written
// corner sequences and random traffic, all checked against a queue-based
// reference model of the writeback arbiter.

module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic              A_Valid = 1'b0;
  logic              A_Ready;
  logic [ADDR_W-1:0] A_Reg = '0;
  logic [DATA_W-1:0] A_Data = '0;
  logic              B_Valid = 1'b0;
  logic              B_Ready;
  logic [ADDR_W-1:0] B_Reg = '0;
  logic [DATA_W-1:0] B_Data = '0;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] QueryReg1 = '0;
  logic [ADDR_W-1:0] QueryReg2 = '0;
  logic              Hazard1;
  logic              Hazard2;
  logic [CNT_W-1:0]  WriteCount;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Reg(A_Reg), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Reg(B_Reg), .B_Data(B_Data),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .QueryReg1(QueryReg1), .QueryReg2(QueryReg2),
    .Hazard1(Hazard1), .Hazard2(Hazard2), .WriteCount(WriteCount)
  );

  // Register file as seen through the DUT's write port
  logic [DATA_W-1:0] dut_rf [32];
  initial for (int i = 0; i < 32; i++) dut_rf[i] = '0;
  always @(posedge Clk) if (RegWrite) dut_rf[WriteRegister] <= WriteData;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each requester's buffer is a queue holding at most one pending write;
  // the write stage is a single pending commit.
  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               qa[$];
  wr_t               qb[$];
  bit                m_last_b;
  bit                m_we;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;
  logic [CNT_W-1:0]  m_cnt;
  logic [DATA_W-1:0] m_rf [32];
  initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

  function automatic int m_pick();  // 0 none, 1 A, 2 B
    if (qa.size() != 0 && qb.size() != 0) begin
      if (qa[0].r == qb[0].r) return 1;
      return m_last_b ? 1 : 2;
    end
    if (qa.size() != 0) return 1;
    if (qb.size() != 0) return 2;
    return 0;
  endfunction

  function automatic bit m_hazard(input logic [ADDR_W-1:0] q);
    if (q == 0) return 1'b0;
    if (qa.size() != 0 && qa[0].r == q) return 1'b1;
    if (qb.size() != 0 && qb[0].r == q) return 1'b1;
    return m_we && (m_wreg == q);
  endfunction

  function automatic void m_reset();
    qa.delete();
    qb.delete();
    m_last_b = 1'b1;
    m_we     = 1'b0;
    m_wreg   = '0;
    m_wdata  = '0;
    m_cnt    = '0;
  endfunction

  // Compare all outputs against the model, then advance the model by one
  // edge using the current inputs, and move to just after that edge.
  task automatic model_cycle();
    int  g;
    bit  a_rdy, b_rdy;
    wr_t e;
    g     = m_pick();
    a_rdy = (qa.size() == 0) || (g == 1);
    b_rdy = (qb.size() == 0) || (g == 2);
    check("model A_Ready", 32'(A_Ready), 32'(a_rdy));
    check("model B_Ready", 32'(B_Ready), 32'(b_rdy));
    check("model RegWrite", 32'(RegWrite), 32'(m_we));
    check("model WriteRegister", 32'(WriteRegister), 32'(m_wreg));
    check("model WriteData", WriteData, m_wdata);
    check("model WriteCount", WriteCount, m_cnt);
    check("model Hazard1", 32'(Hazard1), 32'(m_hazard(QueryReg1)));
    check("model Hazard2", 32'(Hazard2), 32'(m_hazard(QueryReg2)));
    if (m_we) m_rf[m_wreg] = m_wdata;
    if (g != 0) begin
      e        = (g == 1) ? qa.pop_front() : qb.pop_front();
      m_we     = 1'b1;
      m_wreg   = e.r;
      m_wdata  = e.d;
      m_cnt    = m_cnt + 1;
      m_last_b = (g == 2);
    end else begin
      m_we = 1'b0;
    end
    if (A_Valid && a_rdy && A_Reg != 0) qa.push_back('{r: A_Reg, d: A_Data});
    if (B_Valid && b_rdy && B_Reg != 0) qb.push_back('{r: B_Reg, d: B_Data});
    @(posedge Clk);
    #1;
  endtask

  task automatic step();
    @(negedge Clk);
    model_cycle();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    A_Valid = 1'b0; A_Reg = '0; A_Data = '0;
    B_Valid = 1'b0; B_Reg = '0; B_Data = '0;
  endtask

  task automatic drive_a(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    A_Valid = v; A_Reg = r; A_Data = d;
  endtask

  task automatic drive_b(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    B_Valid = v; B_Reg = r; B_Data = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic              a_v;
    logic [ADDR_W-1:0] a_r;
    logic [DATA_W-1:0] a_d;
    logic              b_v;
    logic [ADDR_W-1:0] b_r;
    logic [DATA_W-1:0] b_d;
    logic [ADDR_W-1:0] q1;
    logic [ADDR_W-1:0] q2;
    logic              e_ar;
    logic              e_br;
    logic              e_rw;
    logic [ADDR_W-1:0] e_wr;
    logic [DATA_W-1:0] e_wd;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_h1;
    logic              e_h2;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    // Expected columns are the outputs seen during the row's cycle, before
    // the edge that samples the row's inputs. Starts from reset.
    //           aV aR  aD     bV bR  bD    q1 q2  AR BR RW WR WD     CNT H1 H2
    vecs[0] = '{1, 3, 'h11,  1, 4, 'h22,  3, 4,  1, 1, 0, 0, 'h0,  0, 0, 0};
    vecs[1] = '{0, 0, 'h0,   0, 0, 'h0,   3, 4,  1, 0, 0, 0, 'h0,  0, 1, 1};
    vecs[2] = '{0, 0, 'h0,   0, 0, 'h0,   3, 4,  1, 1, 1, 3, 'h11, 1, 1, 1};
    vecs[3] = '{1, 3, 'h33,  1, 4, 'h44,  3, 4,  1, 1, 1, 4, 'h22, 2, 0, 1};
    vecs[4] = '{0, 0, 'h0,   0, 0, 'h0,   3, 4,  1, 0, 0, 4, 'h22, 2, 1, 1};
    vecs[5] = '{0, 0, 'h0,   0, 0, 'h0,   3, 4,  1, 1, 1, 3, 'h33, 3, 1, 1};
    vecs[6] = '{1, 0, 'h55,  0, 0, 'h0,   0, 4,  1, 1, 1, 4, 'h44, 4, 0, 1};
    vecs[7] = '{0, 0, 'h0,   1, 0, 'h66,  0, 4,  1, 1, 0, 4, 'h44, 4, 0, 0};
    vecs[8] = '{0, 0, 'h0,   0, 0, 'h0,   4, 3,  1, 1, 0, 4, 'h44, 4, 0, 0};
  end

  // ---------------- main sequence ----------------
  initial begin
    string p;
    #1;
    do_reset();

    // Reset state
    check("reset RegWrite", 32'(RegWrite), 32'd0);
    check("reset WriteRegister", 32'(WriteRegister), 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    check("reset WriteCount", WriteCount, 32'd0);
    check("reset A_Ready", 32'(A_Ready), 32'd1);
    check("reset B_Ready", 32'(B_Ready), 32'd1);

    // Table: round-robin pairs and register-0 drops
    for (int i = 0; i < NV; i++) begin
      drive_a(vecs[i].a_v, vecs[i].a_r, vecs[i].a_d);
      drive_b(vecs[i].b_v, vecs[i].b_r, vecs[i].b_d);
      QueryReg1 = vecs[i].q1;
      QueryReg2 = vecs[i].q2;
      @(negedge Clk);
      p = $sformatf("row%0d", i);
      check({p, " A_Ready"}, 32'(A_Ready), 32'(vecs[i].e_ar));
      check({p, " B_Ready"}, 32'(B_Ready), 32'(vecs[i].e_br));
      check({p, " RegWrite"}, 32'(RegWrite), 32'(vecs[i].e_rw));
      check({p, " WriteRegister"}, 32'(WriteRegister), 32'(vecs[i].e_wr));
      check({p, " WriteData"}, WriteData, vecs[i].e_wd);
      check({p, " WriteCount"}, WriteCount, vecs[i].e_cnt);
      check({p, " Hazard1"}, 32'(Hazard1), 32'(vecs[i].e_h1));
      check({p, " Hazard2"}, 32'(Hazard2), 32'(vecs[i].e_h2));
      model_cycle();
    end
    idle_inputs();

    // Single write latency: accept, one cycle in the buffer, then RegWrite
    do_reset();
    drive_a(1, 5, 32'hDEADBEEF);
    @(negedge Clk);
    check("lat accept A_Ready", 32'(A_Ready), 32'd1);
    model_cycle();
    idle_inputs();
    @(negedge Clk);
    check("lat N+1 RegWrite", 32'(RegWrite), 32'd0);
    model_cycle();
    @(negedge Clk);
    check("lat N+2 RegWrite", 32'(RegWrite), 32'd1);
    check("lat N+2 WriteRegister", 32'(WriteRegister), 32'd5);
    check("lat N+2 WriteData", WriteData, 32'hDEADBEEF);
    check("lat N+2 WriteCount", WriteCount, 32'd1);
    model_cycle();
    @(negedge Clk);
    check("lat N+3 RegWrite", 32'(RegWrite), 32'd0);
    model_cycle();

    // Same destination with last grant = A: A must still go first
    do_reset();
    drive_a(1, 1, 32'h01);
    step();
    idle_inputs();
    step();
    step();
    drive_a(1, 7, 32'hAA);
    drive_b(1, 7, 32'hBB);
    step();
    idle_inputs();
    @(negedge Clk);
    check("same-reg A_Ready", 32'(A_Ready), 32'd1);
    check("same-reg B_Ready", 32'(B_Ready), 32'd0);
    model_cycle();
    @(negedge Clk);
    check("same-reg first data", WriteData, 32'hAA);
    model_cycle();
    @(negedge Clk);
    check("same-reg second reg", 32'(WriteRegister), 32'd7);
    check("same-reg second data", WriteData, 32'hBB);
    model_cycle();
    step();
    check("same-reg regfile r7", dut_rf[7], 32'hBB);

    // B parked while A streams back-to-back
    do_reset();
    QueryReg2 = 9;
    drive_a(1, 1, 32'hA0);
    drive_b(1, 9, 32'hB0);
    step();
    drive_b(0, 0, 0);
    drive_a(1, 2, 32'hA1);
    @(negedge Clk);
    check("stream c1 B_Ready", 32'(B_Ready), 32'd0);
    check("stream c1 A_Ready", 32'(A_Ready), 32'd1);
    check("stream c1 Hazard2", 32'(Hazard2), 32'd1);
    model_cycle();
    drive_a(1, 3, 32'hA2);
    @(negedge Clk);
    check("stream c2 A_Ready", 32'(A_Ready), 32'd0);
    check("stream c2 B_Ready", 32'(B_Ready), 32'd1);
    check("stream c2 Hazard2", 32'(Hazard2), 32'd1);
    model_cycle();
    @(negedge Clk);  // A still presents reg 3, not yet accepted
    check("stream c3 RegWrite", 32'(RegWrite), 32'd1);
    check("stream c3 WriteRegister", 32'(WriteRegister), 32'd9);
    check("stream c3 Hazard2", 32'(Hazard2), 32'd1);
    model_cycle();
    drive_a(1, 4, 32'hA3);
    @(negedge Clk);
    check("stream c4 Hazard2", 32'(Hazard2), 32'd0);
    model_cycle();
    idle_inputs();
    repeat (4) step();

    // Reset with both buffers full and a write in the stage
    do_reset();
    drive_a(1, 1, 32'h101);
    drive_b(1, 6, 32'h606);
    step();
    drive_a(1, 2, 32'h202);
    drive_b(0, 0, 0);
    step();
    idle_inputs();
    check("midrst pre RegWrite", 32'(RegWrite), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("midrst async RegWrite", 32'(RegWrite), 32'd0);
    check("midrst WriteCount", WriteCount, 32'd0);
    m_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst A_Ready", 32'(A_Ready), 32'd1);
    check("midrst B_Ready", 32'(B_Ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("midrst no write", 32'(RegWrite), 32'd0);
      model_cycle();
    end
    check("midrst WriteCount after", WriteCount, 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive_a($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 7)), $urandom);
      drive_b($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 7)), $urandom);
      QueryReg1 = ADDR_W'($urandom_range(0, 7));
      QueryReg2 = ADDR_W'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    repeat (4) step();
    for (int i = 0; i < 32; i++) check($sformatf("regfile r%0d", i), dut_rf[i], m_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
